// File: rtl/stream_fifo.sv
// Synchronous valid/ready stream FIFO with registered outputs and no bypass path.
// Define STREAM_FIFO_COUNT_EN to expose the occupancy on the count port.
module stream_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef STREAM_FIFO_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0] count
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntZero = '0;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] occ_q, occ_d;

    logic push;
    logic pop;

    // Handshake flags depend only on registered occupancy, never on the peer's inputs.
    assign in_ready  = (occ_q != CntFull);
    assign out_valid = (occ_q != CntZero);
    assign out       = mem_q[rd_ptr_q];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + CntOne;
            2'b01:   occ_d = occ_q - CntOne;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is deliberately not reset; its contents are ignored while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

`ifdef STREAM_FIFO_COUNT_EN
    assign count = occ_q;
`endif

endmodule
